// File: rtl/avl_bus_type.sv
// Shared types and constants for the avl bus.
//   AVL_BAD_READ_DATA : data returned for a read that misses the slave's address window
//   avl_rsp_t         : one read-response entry as held in a slave's response FIFO
//   avl_addr_in_range : window check done in 33 bits so a window ending at 2**32 cannot wrap
package avl_bus_type;

    localparam logic [31:0] AVL_BAD_READ_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] data;
    } avl_rsp_t;

    function automatic logic avl_addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned aw
    );
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + (33'd4 << aw);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/avl_resp_fifo.sv
// Show-ahead response FIFO: the head entry is on dout whenever empty=0.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (pointers/count only)
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dout         : head entry
//   full, empty  : status flags
//   count        : current occupancy, 0..DEPTH
module avl_resp_fifo
    import avl_bus_type::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  avl_rsp_t               din,
    input  logic                   pop,
    output avl_rsp_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    avl_rsp_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/avl_bus_slave_ram.sv
// Avalon-style bus slave: word-addressed on-chip RAM with in-order read
// responses through a fixed-latency pipeline and a show-ahead response FIFO.
// Ports:
//   clk, rest                  : clock, asynchronous active-high reset
//   address, byte_en           : byte address ([1:0] ignored), write byte lanes
//   read, write, write_data    : command strobes and write payload
//   request_ready              : a command is accepted this cycle if asserted
//   read_data, read_data_valid : response at the FIFO head
//   resp_ready                 : master consumes the head response
//   bad_cmd                    : one-cycle pulse after an out-of-range or read+write accept
module avl_bus_slave_ram
    import avl_bus_type::*;
#(
    parameter int          ADDR_WIDTH      = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          READ_LATENCY    = 1,
    parameter int          RESP_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] address,
    input  logic [3:0]  byte_en,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] write_data,
    output logic        request_ready,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        resp_ready,
    output logic        bad_cmd
);

    localparam int OW = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int CW = $clog2(RESP_FIFO_DEPTH) + 1;

    logic [31:0]           ram [2**ADDR_WIDTH];

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rsp_pop;
    logic [OW-1:0]         outstanding;

    logic                  vld_p  [READ_LATENCY];
    logic                  oor_p  [READ_LATENCY];
    logic [31:0]           word_p [READ_LATENCY];

    avl_rsp_t              fifo_din;
    avl_rsp_t              fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;

    // Decode and command qualification
    assign offset   = address - BASE_ADDR;
    assign word_idx = offset[ADDR_WIDTH+1:2];
    assign in_range = avl_addr_in_range(address, BASE_ADDR, ADDR_WIDTH);

    // Outstanding covers pipeline plus FIFO, so an accepted read always has a FIFO slot
    assign request_ready = !rest && (outstanding < OW'(RESP_FIFO_DEPTH));
    assign accept        = (read || write) && request_ready;
    assign wr_acc        = accept && write && in_range;
    // read+write together: the write wins and the read never gets a response
    assign rd_acc        = accept && read && !write;
    assign rsp_pop       = read_data_valid && resp_ready;

    // RAM: byte-lane writes, registered read forms pipeline stage p0
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[word_idx][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            word_p[0] <= ram[word_idx];
            oor_p[0]  <= !in_range;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            word_p[i] <= word_p[i-1];
            oor_p[i]  <= oor_p[i-1];
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Outstanding counter and bad-command pulse
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            outstanding <= '0;
            bad_cmd     <= 1'b0;
        end else begin
            case ({rd_acc, rsp_pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            bad_cmd <= accept && (!in_range || (read && write));
        end
    end

    // Last pipeline stage -> response FIFO
    assign fifo_din.data = oor_p[READ_LATENCY-1] ? AVL_BAD_READ_DATA : word_p[READ_LATENCY-1];

    avl_resp_fifo #(
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rest),
        .push  (vld_p[READ_LATENCY-1]),
        .din   (fifo_din),
        .pop   (rsp_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign read_data_valid = !fifo_empty;
    // Forced to zero when empty so reset and idle never show stale FIFO contents
    assign read_data       = read_data_valid ? fifo_dout.data : 32'h0;

    logic unused_ok;
    assign unused_ok = ^{offset[31:ADDR_WIDTH+2], offset[1:0], fifo_full, fifo_count};

endmodule

// File: tb/tb_avl_bus_slave_ram.sv
module tb_avl_bus_slave_ram;

    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          LAT   = 1;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BAD   = 32'hDEAD_BEEF;
    localparam logic [31:0] OOR   = BASE + 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [31:0] address = '0;
    logic [3:0]  byte_en = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] write_data = '0;
    logic        request_ready;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        resp_ready = 1'b0;
    logic        bad_cmd;

    avl_bus_slave_ram #(
        .ADDR_WIDTH      (AW),
        .BASE_ADDR       (BASE),
        .READ_LATENCY    (LAT),
        .RESP_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rest            (rest),
        .address         (address),
        .byte_en         (byte_en),
        .read            (read),
        .write           (write),
        .write_data      (write_data),
        .request_ready   (request_ready),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .resp_ready      (resp_ready),
        .bad_cmd         (bad_cmd)
    );

    always #5 clk = ~clk;

    int now = 0;
    always @(posedge clk) now++;

    int tests = 0;
    int failed = 0;

    // Reference model: memory image plus queue of expected responses in accept order
    typedef struct {
        logic [31:0] data;
        int          avail;
    } ent_t;

    logic [31:0] ref_mem [1024];
    ent_t        q [$];
    logic        exp_bad = 1'b0;
    int          rd_accs = 0;

    logic        smp_rdy, smp_vld, smp_bad;
    logic [31:0] smp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + 64'd4096);
    endfunction

    // One clock cycle: sample at negedge, check against model, advance model, step past posedge
    task automatic cyc();
        logic exp_rdy, exp_vld, nb, inr;
        int   idx;
        ent_t e;
        @(negedge clk);
        if (rest) begin
            q.delete();
            exp_bad = 1'b0;
        end
        exp_rdy = !rest && (q.size() < DEPTH);
        exp_vld = (q.size() > 0) && (q[0].avail <= now);
        smp_rdy = request_ready;
        smp_vld = read_data_valid;
        smp_bad = bad_cmd;
        smp_data = read_data;
        check("request_ready", 32'(request_ready), 32'(exp_rdy));
        check("read_data_valid", 32'(read_data_valid), 32'(exp_vld));
        check("bad_cmd", 32'(bad_cmd), 32'(exp_bad));
        if (exp_vld) check("read_data", read_data, q[0].data);
        if (exp_vld && resp_ready) void'(q.pop_front());
        nb = 1'b0;
        if ((read || write) && exp_rdy) begin
            inr = in_rng(address);
            idx = int'((address - BASE) >> 2) & 1023;
            if (write && inr) begin
                for (int b = 0; b < 4; b++)
                    if (byte_en[b]) ref_mem[idx][8*b +: 8] = write_data[8*b +: 8];
            end
            if (read && !write) begin
                e.data  = inr ? ref_mem[idx] : BAD;
                e.avail = now + 1 + LAT;
                q.push_back(e);
                rd_accs++;
            end
            nb = !inr || (read && write);
        end
        exp_bad = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        read = rd; write = wr; address = a; write_data = d; byte_en = be;
        cyc();
        read = 1'b0; write = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] ev);
        cmd(1'b1, 1'b0, a, 32'h0, 4'h0);
        repeat (LAT) begin
            cyc();
            check({tag, "_early"}, 32'(smp_vld), 32'd0);
        end
        cyc();
        check({tag, "_vld"}, 32'(smp_vld), 32'd1);
        check(tag, smp_data, ev);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        logic [31:0] w0;
        logic        r, w;
        logic [31:0] a;

        // Reset values
        #1;
        check("rst_ready", 32'(request_ready), 32'd0);
        check("rst_valid", 32'(read_data_valid), 32'd0);
        check("rst_data", read_data, 32'h0);
        check("rst_bad", 32'(bad_cmd), 32'd0);
        cyc();
        cyc();
        rest = 1'b0;
        resp_ready = 1'b1;

        // Initialise the words used below so the model never reads unknown RAM
        for (int i = 0; i < 16; i++) cmd(1'b0, 1'b1, BASE + 32'(4*i), $urandom, 4'hF);

        // Basic write/read and latency
        cmd(1'b0, 1'b1, 32'h1000_0004, 32'h1122_3344, 4'hF);
        read_expect("latency_read", 32'h1000_0004, 32'h1122_3344);

        // Byte enables on word 3
        cmd(1'b0, 1'b1, BASE + 32'd12, 32'hFFFF_FFFF, 4'hF);
        cmd(1'b0, 1'b1, BASE + 32'd12, 32'h0000_00AB, 4'b0001);
        read_expect("byte_lane", BASE + 32'd12, 32'hFFFF_FFAB);
        cmd(1'b0, 1'b1, BASE + 32'd12, 32'h0000_0000, 4'b0000);
        read_expect("be_zero", BASE + 32'd12, 32'hFFFF_FFAB);

        // Backpressure: only DEPTH reads accepted while resp_ready is low
        resp_ready = 1'b0;
        a0 = rd_accs;
        for (int i = 0; i < 6; i++) cmd(1'b1, 1'b0, BASE + 32'(4*i), 32'h0, 4'h0);
        check("bp_accepted", 32'(rd_accs - a0), 32'(DEPTH));
        check("bp_ready_low", 32'(smp_rdy), 32'd0);
        cyc();
        cyc();
        check("bp_hold_vld", 32'(smp_vld), 32'd1);
        resp_ready = 1'b1;
        cyc();
        cyc();
        check("bp_ready_back", 32'(smp_rdy), 32'd1);
        repeat (6) cyc();

        // Out-of-range reads above and below the window
        cmd(1'b1, 1'b0, OOR, 32'h0, 4'h0);
        cyc();
        check("oor_bad_pulse", 32'(smp_bad), 32'd1);
        repeat (LAT - 1) cyc();
        cyc();
        check("oor_bad_once", 32'(smp_bad), 32'd0);
        check("oor_vld", 32'(smp_vld), 32'd1);
        check("oor_data", smp_data, BAD);
        read_expect("below_base", BASE - 32'd4, BAD);

        // Out-of-range write leaves RAM (including the aliased word 0) alone
        w0 = ref_mem[0];
        cmd(1'b0, 1'b1, OOR, 32'h5555_5555, 4'hF);
        cyc();
        check("oor_wr_bad", 32'(smp_bad), 32'd1);
        read_expect("oor_wr_ram", BASE, w0);

        // read and write together: write lands, no response
        cmd(1'b1, 1'b1, BASE + 32'd20, 32'hCAFE_F00D, 4'hF);
        cyc();
        check("rw_bad", 32'(smp_bad), 32'd1);
        repeat (LAT) cyc();
        check("rw_no_resp", 32'(smp_vld), 32'd0);
        check("rw_ready", 32'(smp_rdy), 32'd1);
        read_expect("rw_write", BASE + 32'd20, 32'hCAFE_F00D);

        // Reset with reads in flight
        resp_ready = 1'b0;
        cmd(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'h0);
        cmd(1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0);
        cmd(1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
        rest = 1'b1;
        #1;
        check("arst_valid", 32'(read_data_valid), 32'd0);
        check("arst_data", read_data, 32'h0);
        check("arst_ready", 32'(request_ready), 32'd0);
        cyc();
        rest = 1'b0;
        resp_ready = 1'b1;
        repeat (4) cyc();
        check("arst_no_stale", 32'(smp_vld), 32'd0);
        read_expect("arst_ram1", BASE + 32'd4, 32'h1122_3344);
        read_expect("arst_ram3", BASE + 32'd12, 32'hFFFF_FFAB);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 2) != 0);
            w = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                a = OOR + 32'(4 * $urandom_range(0, 3));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            cmd(r, w, a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Drain
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
        check("drain_empty", 32'(q.size()), 32'd0);
        cyc();
        check("drain_vld", 32'(smp_vld), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
